// File: rtl/rcs_seq_31bit.sv
// rcs_seq_31bit: sequential ripple-borrow subtractor.
// Computes i_sub_term1 - i_sub_term2 over STEPS cycles, DIGIT bits per cycle.
// The borrow is held in a register between cycles, so the critical path is
// only a DIGIT-bit borrow chain. Valid/ready handshakes sit on both sides.
module rcs_seq_31bit #(
   parameter int WIDTH = 31,
   parameter int DIGIT = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_sub_term1,
   input  logic [WIDTH-1:0] i_sub_term2,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH:0]   o_result,
   output logic             o_busy
);

   // Number of compute cycles and the zero-padded operand width.
   localparam int STEPS  = (WIDTH + DIGIT - 1) / DIGIT;
   localparam int PW     = STEPS * DIGIT;
   localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic                borrow_q, borrow_d;
   logic [PW-1:0]       a_q, a_d;
   logic [PW-1:0]       b_q, b_d;
   logic [WIDTH-1:0]    diff_q, diff_d;
   logic                o_ready_q;
   logic                o_valid_q;
   logic                o_busy_q;

   logic [DIGIT-1:0]    a_chunk;
   logic [DIGIT-1:0]    b_chunk;
   logic [DIGIT:0]      chunk_res;
   logic [PW-1:0]       diff_wr;
   logic                last_step;

   // Select the active chunk, subtract it with the held borrow, and merge the
   // digit into a padded copy of the difference. Bits of the padded copy above
   // WIDTH are discarded, so a partial last chunk only stores its real bits.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int k = 0; k < STEPS; k++) begin
         if (step_q == STEP_W'(k)) begin
            a_chunk = a_q[k*DIGIT +: DIGIT];
            b_chunk = b_q[k*DIGIT +: DIGIT];
         end
      end
      chunk_res = {1'b0, a_chunk} - {1'b0, b_chunk} - (DIGIT+1)'(borrow_q);
      diff_wr   = PW'(diff_q);
      for (int k = 0; k < STEPS; k++) begin
         if (step_q == STEP_W'(k)) begin
            diff_wr[k*DIGIT +: DIGIT] = chunk_res[DIGIT-1:0];
         end
      end
      last_step = (step_q == STEP_W'(STEPS - 1));
   end

   // Next-state logic for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      borrow_d = borrow_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      case (state_q)
         ST_IDLE: begin
            if (i_valid && o_ready_q) begin
               a_d      = PW'(i_sub_term1);
               b_d      = PW'(i_sub_term2);
               borrow_d = 1'b0;
               step_d   = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            diff_d   = diff_wr[WIDTH-1:0];
            borrow_d = chunk_res[DIGIT];
            if (last_step) begin
               state_d = ST_DONE;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         ST_DONE: begin
            // Result is held untouched until downstream takes it.
            if (i_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, datapath registers and registered handshake outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         step_q    <= '0;
         borrow_q  <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         diff_q    <= '0;
         o_ready_q <= 1'b1;
         o_valid_q <= 1'b0;
         o_busy_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         borrow_q  <= borrow_d;
         a_q       <= a_d;
         b_q       <= b_d;
         diff_q    <= diff_d;
         o_ready_q <= (state_d == ST_IDLE);
         o_valid_q <= (state_d == ST_DONE);
         o_busy_q  <= (state_d == ST_RUN);
      end
   end

   assign o_ready  = o_ready_q;
   assign o_valid  = o_valid_q;
   assign o_busy   = o_busy_q;
   // Only a finished result is ever driven; otherwise the bus reads zero.
   assign o_result = o_valid_q ? {borrow_q, diff_q} : '0;

endmodule
